// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan controller.
//   - state_e     : digit slot encoding D0..D3
//   - AN_*        : active-low anode patterns per slot, AN_OFF = all dark
//   - SEG_OFF     : all segments dark
//   - FONT_0..F   : active-low {g,f,e,d,c,b,a} hex font
package seg_pkg;

   typedef enum logic [1:0] {
      D0 = 2'b00,
      D1 = 2'b01,
      D2 = 2'b10,
      D3 = 2'b11
   } state_e;

   localparam logic [3:0] AN_D0  = 4'b0111;
   localparam logic [3:0] AN_D1  = 4'b1011;
   localparam logic [3:0] AN_D2  = 4'b1101;
   localparam logic [3:0] AN_D3  = 4'b1110;
   localparam logic [3:0] AN_OFF = 4'b1111;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] FONT_0 = 7'b1000000;
   localparam logic [6:0] FONT_1 = 7'b1111001;
   localparam logic [6:0] FONT_2 = 7'b0100100;
   localparam logic [6:0] FONT_3 = 7'b0110000;
   localparam logic [6:0] FONT_4 = 7'b0011001;
   localparam logic [6:0] FONT_5 = 7'b0010010;
   localparam logic [6:0] FONT_6 = 7'b0000010;
   localparam logic [6:0] FONT_7 = 7'b1111000;
   localparam logic [6:0] FONT_8 = 7'b0000000;
   localparam logic [6:0] FONT_9 = 7'b0010000;
   localparam logic [6:0] FONT_A = 7'b0001000;
   localparam logic [6:0] FONT_B = 7'b0000011;
   localparam logic [6:0] FONT_C = 7'b1000110;
   localparam logic [6:0] FONT_D = 7'b0100001;
   localparam logic [6:0] FONT_E = 7'b0000110;
   localparam logic [6:0] FONT_F = 7'b0001110;

endpackage : seg_pkg

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg_c  : {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   always_comb begin : decode
      seg_c = SEG_OFF;
      case (nibble)
         4'h0: seg_c = FONT_0;
         4'h1: seg_c = FONT_1;
         4'h2: seg_c = FONT_2;
         4'h3: seg_c = FONT_3;
         4'h4: seg_c = FONT_4;
         4'h5: seg_c = FONT_5;
         4'h6: seg_c = FONT_6;
         4'h7: seg_c = FONT_7;
         4'h8: seg_c = FONT_8;
         4'h9: seg_c = FONT_9;
         4'hA: seg_c = FONT_A;
         4'hB: seg_c = FONT_B;
         4'hC: seg_c = FONT_C;
         4'hD: seg_c = FONT_D;
         4'hE: seg_c = FONT_E;
         4'hF: seg_c = FONT_F;
         default: seg_c = SEG_OFF;
      endcase
   end

endmodule : hex_to_7seg

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scan sequencer.
//   CLK, RST_N   : clock, async active-low reset
//   ENABLE       : scan enable (low freezes scan, blanks anodes)
//   LOAD, VALUE, DP_IN : shadow-register write, applied at frame boundary
//   DIGIT_EN, LZ_SUPPRESS : live per-digit enable and leading-zero blanking
//   AN, SEG, DP_N : active-low display drive
//   DIGIT_SEL    : active digit index
//   FRAME_TICK, ACK : one-cycle frame boundary / data-applied pulses
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter int unsigned DIV_WIDTH    = 17
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ENABLE,
   input  logic        LOAD,
   input  logic [15:0] VALUE,
   input  logic [3:0]  DP_IN,
   input  logic [3:0]  DIGIT_EN,
   input  logic        LZ_SUPPRESS,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP_N,
   output logic [1:0]  DIGIT_SEL,
   output logic        FRAME_TICK,
   output logic        ACK
);

   state_e                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
   logic [15:0]            shadow_val_q, shadow_val_d;
   logic [3:0]             shadow_dp_q, shadow_dp_d;
   logic                   pending_q, pending_d;
   logic [15:0]            disp_val_q, disp_val_d;
   logic [3:0]             disp_dp_q, disp_dp_d;
   logic [3:0]             an_q, an_d;
   logic [6:0]             seg_q, seg_d;
   logic                   dp_n_q, dp_n_d;
   logic [1:0]             digit_sel_q, digit_sel_d;
   logic                   frame_tick_q, frame_tick_d;
   logic                   ack_q, ack_d;

   logic                   last_cnt;
   logic                   boundary;
   logic                   in_window;
   logic                   z0, z1, z2;
   logic [3:0]             nibble;
   logic [3:0]             an_pat;
   logic                   dp_bit;
   logic                   dig_en;
   logic                   lz_dark;
   logic [6:0]             font_c;

   assign last_cnt  = (cnt_q == DIV_WIDTH'(REFRESH_DIV - 1));
   assign boundary  = ENABLE && last_cnt && (state_q == D3);
   assign in_window = (cnt_q >= DIV_WIDTH'(BLANK_CYCLES));

   // Leading-zero chain: a digit is a leading zero only if everything left of it is too.
   assign z0 = (disp_val_q[15:12] == 4'h0);
   assign z1 = z0 && (disp_val_q[11:8] == 4'h0);
   assign z2 = z1 && (disp_val_q[7:4] == 4'h0);

   // Slot FSM and prescaler next state.
   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ENABLE) begin
         if (last_cnt) begin
            cnt_d = '0;
            case (state_q)
               D0: state_d = D1;
               D1: state_d = D2;
               D2: state_d = D3;
               D3: state_d = D0;
               default: state_d = D0;
            endcase
         end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
         end
      end
   end

   // Per-slot digit selection.
   always_comb begin : digit_mux
      nibble  = disp_val_q[15:12];
      an_pat  = AN_D0;
      dp_bit  = disp_dp_q[3];
      dig_en  = DIGIT_EN[3];
      lz_dark = 1'b0;
      case (state_q)
         D0: begin
            nibble = disp_val_q[15:12]; an_pat = AN_D0;
            dp_bit = disp_dp_q[3];      dig_en = DIGIT_EN[3]; lz_dark = z0;
         end
         D1: begin
            nibble = disp_val_q[11:8];  an_pat = AN_D1;
            dp_bit = disp_dp_q[2];      dig_en = DIGIT_EN[2]; lz_dark = z1;
         end
         D2: begin
            nibble = disp_val_q[7:4];   an_pat = AN_D2;
            dp_bit = disp_dp_q[1];      dig_en = DIGIT_EN[1]; lz_dark = z2;
         end
         D3: begin
            nibble = disp_val_q[3:0];   an_pat = AN_D3;
            dp_bit = disp_dp_q[0];      dig_en = DIGIT_EN[0]; lz_dark = 1'b0;
         end
         default: ;
      endcase
   end

   hex_to_7seg u_hex_to_7seg (
      .nibble (nibble),
      .seg_c  (font_c)
   );

   // Shadow register handshake; a LOAD coinciding with the boundary goes straight to display.
   always_comb begin : shadow_next
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pending_d    = pending_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      if (LOAD) begin
         shadow_val_d = VALUE;
         shadow_dp_d  = DP_IN;
         pending_d    = 1'b1;
      end
      if (boundary) begin
         if (LOAD) begin
            disp_val_d = VALUE;
            disp_dp_d  = DP_IN;
         end else if (pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
         pending_d = 1'b0;
      end
   end

   // Registered display outputs; only the anode is gated by blanking and enables.
   always_comb begin : out_next
      an_d         = AN_OFF;
      seg_d        = font_c;
      dp_n_d       = ~dp_bit;
      digit_sel_d  = state_q;
      frame_tick_d = boundary;
      ack_d        = boundary && (pending_q || LOAD);
      if (ENABLE && in_window && dig_en && !(LZ_SUPPRESS && lz_dark)) begin
         an_d = an_pat;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin : regs
      if (!RST_N) begin
         state_q      <= D0;
         cnt_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_n_q       <= 1'b1;
         digit_sel_q  <= 2'b00;
         frame_tick_q <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         digit_sel_q  <= digit_sel_d;
         frame_tick_q <= frame_tick_d;
         ack_q        <= ack_d;
      end
   end

   assign AN         = an_q;
   assign SEG        = seg_q;
   assign DP_N       = dp_n_q;
   assign DIGIT_SEL  = digit_sel_q;
   assign FRAME_TICK = frame_tick_q;
   assign ACK        = ack_q;

endmodule : seg_scan_ctrl

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencer for the 4-digit multiplexed seven-segment display.
- Generates the digit-scan rate from the system clock and walks the anode ring 0111 -> 1011 -> 1101 -> 1110.
- Decodes the selected hex nibble to segments, and applies per-digit enable, leading-zero suppression, decimal points and anti-ghost blanking.
- Displayed value changes only at frame boundaries, through a LOAD/ACK shadow-register handshake.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- DIV_WIDTH, 17: prescaler counter width; must satisfy 2^DIV_WIDTH >= REFRESH_DIV.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  scan enable; low freezes the scan and blanks the display.
- LOAD  in  1  one-cycle strobe that captures VALUE and DP_IN into the shadow register.
- VALUE  in  16  four hex nibbles; [15:12] is digit 0 (leftmost), [3:0] is digit 3.
- DP_IN  in  4  decimal points, active-high; bit 3 is digit 0.
- DIGIT_EN  in  4  per-digit enable, live (not shadowed); bit 3 is digit 0.
- LZ_SUPPRESS  in  1  blanks leading zero digits.
- AN  out  4  anodes, active-low.
- SEG  out  7  {g,f,e,d,c,b,a}, active-low.
- DP_N  out  1  decimal point, active-low.
- DIGIT_SEL  out  2  index of the active digit.
- FRAME_TICK  out  1  one-cycle pulse at each frame boundary.
- ACK  out  1  one-cycle pulse when shadowed data becomes displayed.

Behaviour:
- Reset (async on RST_N low, all registers):
  - AN=1111, SEG=1111111, DP_N=1, DIGIT_SEL=00, FRAME_TICK=0, ACK=0.
  - Internal state: display value=0000, display DP=0000, pending=0, prescaler=0, state=D0.
- States and digit mapping:
  - D0: AN=0111, DIGIT_SEL=00, nibble [15:12].
  - D1: AN=1011, DIGIT_SEL=01, nibble [11:8].
  - D2: AN=1101, DIGIT_SEL=10, nibble [7:4].
  - D3: AN=1110, DIGIT_SEL=11, nibble [3:0].
- Prescaler and slot advance:
  - With ENABLE=1, cnt counts 0..REFRESH_DIV-1.
  - When cnt==REFRESH_DIV-1, cnt wraps to 0 and the state advances D0->D1->D2->D3->D0.
- Output timing: all outputs are registered from (state, cnt); latency is 1 cycle.
- Anode drive:
  - The active anode is driven only while BLANK_CYCLES <= cnt <= REFRESH_DIV-1; otherwise AN=1111.
  - SEG, DP_N and DIGIT_SEL follow the current state regardless of blanking.
- Per-digit blanking: a digit is dark (its AN bit stays 1) if either
  - its DIGIT_EN bit is 0, or
  - LZ_SUPPRESS=1, its nibble is 0, and all nibbles to its left are 0.
  - Digit 3 is never LZ-suppressed.
- ENABLE=0:
  - cnt and state hold; AN=1111 on the next cycle.
  - When ENABLE returns to 1, scanning resumes from the held position.
- Frame boundary: the cycle with state==D3, cnt==REFRESH_DIV-1 and ENABLE=1.
  - FRAME_TICK pulses on the following cycle.
- LOAD handshake:
  - LOAD=1 writes VALUE/DP_IN to the shadow register and sets pending.
  - A repeated LOAD before the boundary overwrites the shadow (last write wins).
  - At a boundary with pending=1: display registers <= shadow, pending clears, and ACK pulses on the following cycle, coincident with FRAME_TICK.
  - LOAD in the same cycle as the boundary bypasses the shadow: that VALUE is displayed from D0 of the new frame and ACK pulses.
  - With ENABLE=0, no boundary occurs, so pending holds.
- Reset mid-frame: outputs go dark immediately (async); pending data is discarded and no ACK is issued.
- Hex font (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Decomposition:
- Package seg_pkg holds:
  - state encoding D0..D3 (2'b00..2'b11);
  - anode patterns 0111/1011/1101/1110 and AN_OFF=1111;
  - SEG_OFF=1111111;
  - the 16-entry hex font constants.
- One combinational sub-module, hex_to_7seg (4-bit in, 7-bit active-low out), is instantiated once.
- Prescaler, FSM and shadow logic stay in seg_scan_ctrl.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset: assert RST_N=0 mid-slot -> AN=1111, SEG=1111111, DP_N=1, ACK=0 immediately.
  - After release with ENABLE=1: first AN=0111 appears 3 cycles after release; digits 0..3 cycle every 8 cycles.
- Display load: LOAD VALUE=16'h12AF, DP_IN=0100, then run one frame.
  - ACK and FRAME_TICK pulse together once.
  - Next frame shows SEG=1111001, 0100100, 0001000, 0001110 on digits 0..3.
  - DP_N=0 only on digit 1.
- Overwrite and bypass:
  - LOAD 16'h1111 then 16'h2222 inside one frame -> single ACK; 2222 is displayed.
  - LOAD asserted exactly at the boundary -> that value shows from the next D0, with ACK.
- Leading-zero suppression and digit enables:
  - VALUE=16'h0005, LZ_SUPPRESS=1 -> AN stays 1111 for digits 0-2; digit 3 shows 0010010.
  - VALUE=16'h0000 -> only digit 3 lit, showing 1000000.
  - DIGIT_EN=1011 -> digit 1 is never lit.
- Freeze: drop ENABLE mid D2 for 20 cycles -> AN=1111, DIGIT_SEL holds 10, no FRAME_TICK.
  - After ENABLE rises, the remaining D2 cycles complete before D3.
- Blanking window: in every slot, AN=1111 for exactly 2 cycles, then the digit's anode is low for 6 cycles.
